// File: rtl/gate_response_checker.sv
// gate_response_checker
//   Self-checking sink for basic-gate test fixtures. It compares each accepted
//   vector against the truth table of seven gates, given {a,b} and the gate
//   outputs. Over one run of NUM_VECTORS accepted vectors it collects the
//   following results:
//     - an error count
//     - the index of the first failing vector
//     - input-combination coverage
//     - a 16-bit MISR signature
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     start               begin a run (IDLE/DONE only), clears all results
//     sample_valid        a, b, g_* valid this cycle (no backpressure)
//     a, b                gate stimulus
//     g_and .. g_xnor     gate outputs under test
//     busy, done          run in progress / run complete
//     pass                done with no errors and full coverage
//     err_pulse           previous accepted vector mismatched
//     err_count           saturating mismatch count
//     first_err_vld/idx   first mismatching vector index
//     coverage            bit {a,b} set once that combination was accepted
//     signature           MISR over accepted vectors
module gate_response_checker #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             g_and,
    input  logic             g_or,
    input  logic             g_nota,
    input  logic             g_nand,
    input  logic             g_nor,
    input  logic             g_xor,
    input  logic             g_xnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_vld,
    output logic [IDX_W-1:0] first_err_idx,
    output logic [3:0]       coverage,
    output logic [15:0]      signature
);

    localparam int unsigned OBS_W     = 7;
    localparam int unsigned SIG_W     = 16;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [SIG_W-1:0] SIG_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   vec_cnt;
    logic               load_c;
    logic               accept_c;
    logic               mismatch_c;
    logic [OBS_W-1:0]   obs_c;
    logic [OBS_W-1:0]   exp_c;
    logic               fb_c;
    logic [SIG_W-1:0]   sig_nxt_c;

    // Observed gate vector and the truth-table expectation for {a,b}
    assign obs_c = {g_xnor, g_xor, g_nor, g_nand, g_nota, g_or, g_and};
    assign exp_c = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt  = state;
        load_c     = 1'b0;
        accept_c   = 1'b0;
        mismatch_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // start is ignored while a run is in progress
                if (sample_valid) begin
                    accept_c   = 1'b1;
                    mismatch_c = (obs_c != exp_c);
                    if (vec_cnt == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // MISR step for the accepted vector
    always_comb begin
        fb_c      = signature[15] ^ signature[13] ^ signature[12] ^ signature[10];
        sig_nxt_c = {signature[14:0], fb_c} ^ {7'b0, obs_c, a, b};
    end

    // State register; busy/done are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
        end
    end

    // Result registers: cleared on start, updated per accepted vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_cnt       <= '0;
            err_pulse     <= 1'b0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            coverage      <= '0;
            signature     <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (load_c) begin
                vec_cnt       <= '0;
                err_count     <= '0;
                first_err_vld <= 1'b0;
                first_err_idx <= '0;
                coverage      <= '0;
                signature     <= SIG_SEED;
            end else if (accept_c) begin
                vec_cnt            <= vec_cnt + IDX_W'(1);
                coverage[{a, b}]   <= 1'b1;
                signature          <= sig_nxt_c;
                err_pulse          <= mismatch_c;
                if (mismatch_c) begin
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                    if (!first_err_vld) begin
                        first_err_vld <= 1'b1;
                        first_err_idx <= vec_cnt;
                    end
                end
            end
        end
    end

    // Pass is a pure decode of frozen result registers
    assign pass = done && (err_count == '0) && (coverage == 4'hF);

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker. A second instance with ERR_W=2
// shares the stimulus so error-count saturation can be observed.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sample_valid = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic g_and = 1'b0, g_or = 1'b0, g_nota = 1'b0, g_nand = 1'b0;
    logic g_nor = 1'b0, g_xor = 1'b0, g_xnor = 1'b0;

    logic       busy, done, pass, err_pulse, first_err_vld;
    logic [7:0] err_count, first_err_idx;
    logic [3:0] coverage;
    logic [15:0] signature;

    logic       s_busy, s_done, s_pass, s_err_pulse, s_first_err_vld;
    logic [1:0] s_err_count;
    logic [7:0] s_first_err_idx;
    logic [3:0] s_coverage;
    logic [15:0] s_signature;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] msig;
    logic [15:0] clean_sig;

    always #5 clk = ~clk;

    gate_response_checker #(.NUM_VECTORS(16), .ERR_W(8), .IDX_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .g_and(g_and), .g_or(g_or), .g_nota(g_nota),
        .g_nand(g_nand), .g_nor(g_nor), .g_xor(g_xor), .g_xnor(g_xnor),
        .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
        .err_count(err_count), .first_err_vld(first_err_vld),
        .first_err_idx(first_err_idx), .coverage(coverage), .signature(signature)
    );

    gate_response_checker #(.NUM_VECTORS(16), .ERR_W(2), .IDX_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
        .a(a), .b(b), .g_and(g_and), .g_or(g_or), .g_nota(g_nota),
        .g_nand(g_nand), .g_nor(g_nor), .g_xor(g_xor), .g_xnor(g_xnor),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_pulse(s_err_pulse),
        .err_count(s_err_count), .first_err_vld(s_first_err_vld),
        .first_err_idx(s_first_err_idx), .coverage(s_coverage), .signature(s_signature)
    );

    function automatic logic [6:0] expv(input logic ai, input logic bi);
        return {~(ai ^ bi), ai ^ bi, ~(ai | bi), ~(ai & bi), ~ai, ai | bi, ai & bi};
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [6:0] o,
                                         input logic ai, input logic bi);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb} ^ {7'b0, o, ai, bi};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; gates = truth table XOR flip; msig tracks accepted vectors
    task automatic send(input logic ai, input logic bi, input logic [6:0] flip,
                        input logic vld);
        logic [6:0] e;
        e = expv(ai, bi) ^ flip;
        a = ai;
        b = bi;
        {g_xnor, g_xor, g_nor, g_nand, g_nota, g_or, g_and} = e;
        sample_valid = vld;
        start = 1'b0;
        if (vld) msig = misr(msig, e, ai, bi);
        @(posedge clk);
        #1;
    endtask

    // Start pulse with a valid (but ignored) sample in the same cycle
    task automatic do_start();
        start = 1'b1;
        sample_valid = 1'b1;
        a = 1'b1;
        b = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sample_valid = 1'b0;
        msig = 16'hFFFF;
    endtask

    task automatic clean_run(input string tag);
        logic [3:0] v;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send(v[1], v[0], 7'h00, 1'b1);
            if (i == 14) chk({tag, "_not_done_at_15"}, {30'b0, busy, done}, 32'h2);
        end
        chk({tag, "_done"},    {30'b0, busy, done}, 32'h1);
        chk({tag, "_errcnt"},  err_count, 32'h0);
        chk({tag, "_cov"},     coverage, 32'hF);
        chk({tag, "_pass"},    pass, 32'h1);
        chk({tag, "_sig"},     signature, msig);
    endtask

    initial begin
        logic [3:0] v;

        // T1: reset dominates start and sample_valid
        rst_n = 1'b0;
        start = 1'b1;
        sample_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t1_busy_done_pass", {29'b0, busy, done, pass}, 32'h0);
        chk("t1_err", {23'b0, err_pulse, err_count}, 32'h0);
        chk("t1_first", {23'b0, first_err_vld, first_err_idx}, 32'h0);
        chk("t1_cov_sig", {12'b0, coverage, signature}, 32'h0);
        chk("t1_sat_err", s_err_count, 32'h0);
        start = 1'b0;
        sample_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t1_idle_after_reset", {30'b0, busy, done}, 32'h0);

        // T2: clean run
        do_start();
        chk("t2_busy_after_start", {30'b0, busy, done}, 32'h2);
        chk("t2_seed", signature, 32'hFFFF);
        chk("t2_start_sample_ignored", coverage, 32'h0);
        clean_run("t2");
        clean_sig = msig;
        // Vectors in DONE are dropped
        send(1'b0, 1'b1, 7'h7F, 1'b1);
        chk("t2_frozen_sig", signature, clean_sig);
        chk("t2_frozen_err", {err_pulse, err_count}, 32'h0);
        chk("t2_frozen_pass", pass, 32'h1);

        // T3: single xor fault on vector 5 ({a,b}=01)
        do_start();
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send(v[1], v[0], (i == 5) ? 7'h20 : 7'h00, 1'b1);
            chk($sformatf("t3_pulse_%0d", i), err_pulse, (i == 5) ? 32'h1 : 32'h0);
        end
        chk("t3_errcnt", err_count, 32'h1);
        chk("t3_first", {23'b0, first_err_vld, first_err_idx}, 32'h105);
        chk("t3_pass", {30'b0, done, pass}, 32'h2);

        // T4: every vector wrong, saturation at ERR_W=2
        do_start();
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send(v[1], v[0], 7'h7F, 1'b1);
        end
        chk("t4_sat_errcnt", s_err_count, 32'h3);
        chk("t4_sat_first", {23'b0, s_first_err_vld, s_first_err_idx}, 32'h100);
        chk("t4_wide_errcnt", err_count, 32'h10);
        chk("t4_pass", {30'b0, s_pass, pass}, 32'h0);

        // T5: coverage hole, only 00 and 11
        do_start();
        for (int i = 0; i < 16; i++) begin
            send(i[0], i[0], 7'h00, 1'b1);
        end
        chk("t5_done", done, 32'h1);
        chk("t5_cov", coverage, 32'h9);
        chk("t5_errcnt", err_count, 32'h0);
        chk("t5_pass", pass, 32'h0);

        // T6a: gaps between vectors and an ignored start mid-run
        do_start();
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            send(v[1], v[0], 7'h00, 1'b1);
            send(~v[1], v[0], 7'h55, 1'b0);
            if (i == 2) begin
                start = 1'b1;
                sample_valid = 1'b0;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("t6_start_in_run_ignored", coverage, 32'h7);
            end
        end
        chk("t6_gap_sig", signature, clean_sig);
        chk("t6_gap_pass", {29'b0, busy, done, pass}, 32'h3);

        // T6b: reset after vector 7 aborts the run
        do_start();
        for (int i = 0; i < 8; i++) begin
            v = 4'(i);
            send(v[1], v[0], (i == 3) ? 7'h01 : 7'h00, 1'b1);
        end
        chk("t6_pre_abort_err", err_count, 32'h1);
        rst_n = 1'b0;
        send(1'b0, 1'b0, 7'h00, 1'b1);
        chk("t6_abort_state", {29'b0, busy, done, pass}, 32'h0);
        chk("t6_abort_err", {15'b0, err_pulse, err_count, first_err_vld, first_err_idx}, 32'h0);
        chk("t6_abort_cov_sig", {12'b0, coverage, signature}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_start();
        clean_run("t6_rerun");
        chk("t6_rerun_sig_matches_t2", signature, clean_sig);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
